sub_bytes_sequencer: RTL and testbench

// - Applies the byte S-box to all 16 bytes of a 128-bit AES state, N_LANES bytes per clock.
// - Sits directly upstream of byte_substitution_algorithm. It feeds N_LANES instances and collects their outputs.
// - Downstream consumers are ShiftRows/MixColumns.
// - Trades area for latency: 16/N_LANES compute cycles per state; one state in flight.

---
 rtl/sub_bytes_sequencer_pkg.sv | 46 ++++
 rtl/byte_substitution_algorithm.sv | 39 +++
 rtl/sub_bytes_sequencer.sv | 125 ++++++++++++
 tb/tb_sub_bytes_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_bytes_sequencer_pkg.sv
// Shared constants, FSM encoding and GF(2^8) S-box arithmetic for the sub_bytes_sequencer slice.
package sub_bytes_sequencer_pkg;

   localparam int NB_BYTE_C     = 8;
   localparam int NB_STATE_C    = 128;
   localparam int N_STATE_BYTES = 16;

   // Encoding 2'd3 is unused and is treated as IDLE by the sequencer.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_state_t;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] prod;
      logic [7:0] x;
      prod = 8'h00;
      x    = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) prod = prod ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return prod;
   endfunction

   // Multiplicative inverse as x^254; zero maps to zero naturally.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] sbox_byte(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/byte_substitution_algorithm.sv
// Single AES S-box lane; optional output register selected by CREATE_OUTPUT_REG.
module byte_substitution_algorithm
   import sub_bytes_sequencer_pkg::*;
#(
   parameter int NB_BYTE           = 8,
   parameter bit CREATE_OUTPUT_REG = 1'b0
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic [NB_BYTE-1:0] i_byte,
   output logic [NB_BYTE-1:0] o_byte,
   output logic               o_valid
);

   logic [NB_BYTE-1:0] sub_byte;

   assign sub_byte = NB_BYTE'(sbox_byte(i_byte[7:0]));

   generate
      if (CREATE_OUTPUT_REG) begin : g_reg
         always_ff @(posedge i_clock) begin
            if (i_reset) begin
               o_byte  <= '0;
               o_valid <= 1'b0;
            end else begin
               o_byte  <= sub_byte;
               o_valid <= i_valid;
            end
         end
      end else begin : g_comb
         logic unused_clock_reset;
         assign unused_clock_reset = i_clock ^ i_reset;
         assign o_byte  = sub_byte;
         assign o_valid = i_valid;
      end
   endgenerate

endmodule

// File: rtl/sub_bytes_sequencer.sv
// Iterative SubBytes: N_LANES S-boxes per clock over a 128-bit state, one state in flight.
// Optional macro SUB_BYTES_SEQ_STALL_EN holds DONE until the consumer asserts i_ready.
module sub_bytes_sequencer
   import sub_bytes_sequencer_pkg::*;
#(
   parameter int NB_BYTE  = 8,
   parameter int NB_STATE = 128,
   parameter int N_LANES  = 4
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic [NB_STATE-1:0] i_state,
   input  logic                i_valid,
   output logic                o_ready,
   output logic [NB_STATE-1:0] o_state,
   output logic                o_valid,
   input  logic                i_ready
);

   localparam int N_ITER = N_STATE_BYTES / N_LANES;
   localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

   generate
      if (NB_BYTE != NB_BYTE_C || NB_STATE != NB_STATE_C ||
          !(N_LANES == 1 || N_LANES == 2 || N_LANES == 4 || N_LANES == 8 || N_LANES == 16)) begin : g_bad_conf
         $error("BAD_CONF: sub_bytes_sequencer needs NB_BYTE=8, NB_STATE=128, N_LANES in {1,2,4,8,16}");
      end
   endgenerate

   fsm_state_t          state;
   fsm_state_t          state_next;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_next;
   logic [NB_STATE-1:0] work;
   logic [NB_STATE-1:0] work_next;
   logic [NB_BYTE-1:0]  lane_in  [N_LANES];
   logic [NB_BYTE-1:0]  lane_out [N_LANES];
   logic [N_LANES-1:0]  unused_lane_valid;
   logic                ready_raw;

   // Lane j works on byte cnt*N_LANES+j, so byte 0 is substituted first.
   always_comb begin
      for (int j = 0; j < N_LANES; j++) begin
         lane_in[j] = work[(int'(cnt) * N_LANES + j) * NB_BYTE +: NB_BYTE];
      end
   end

   generate
      for (genvar j = 0; j < N_LANES; j++) begin : g_lane
         byte_substitution_algorithm #(
            .NB_BYTE           (NB_BYTE),
            .CREATE_OUTPUT_REG (1'b0)
         ) u_sbox (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_valid (1'b1),
            .i_byte  (lane_in[j]),
            .o_byte  (lane_out[j]),
            .o_valid (unused_lane_valid[j])
         );
      end
   endgenerate

`ifndef SUB_BYTES_SEQ_STALL_EN
   logic unused_ready;
   assign unused_ready = i_ready;
`endif

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         work  <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         work  <= work_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      work_next  = work;
      ready_raw  = 1'b0;
      o_valid    = 1'b0;
      case (state)
         ST_RUN: begin
            for (int j = 0; j < N_LANES; j++) begin
               work_next[(int'(cnt) * N_LANES + j) * NB_BYTE +: NB_BYTE] = lane_out[j];
            end
            if (cnt == CNT_LAST) begin
               state_next = ST_DONE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         ST_DONE: begin
            o_valid = 1'b1;
`ifdef SUB_BYTES_SEQ_STALL_EN
            if (i_ready) state_next = ST_IDLE;
`else
            state_next = ST_IDLE;
`endif
         end
         default: begin
            ready_raw = 1'b1;
            if (i_valid) begin
               work_next  = i_state;
               cnt_next   = '0;
               state_next = ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
      endcase
   end

   // Ready is masked by reset so an upstream source never handshakes into a flushing block.
   assign o_ready = ready_raw & ~i_reset;
   assign o_state = work;

endmodule

// File: tb/tb_sub_bytes_sequencer.sv
// Directed bench for sub_bytes_sequencer with a table-based S-box reference and an N_LANES sweep.
module tb_sub_bytes_sequencer;

   logic         clk = 1'b0;
   logic         i_reset;
   logic         i_valid;
   logic         i_ready;
   logic         o_ready;
   logic         o_valid;
   logic [127:0] i_state;
   logic [127:0] o_state;

   int compared     = 0;
   int mismatched   = 0;
   int sweeps_done  = 0;

   logic [2047:0] sbox_tab = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   always #5 clk = ~clk;

   sub_bytes_sequencer #(.N_LANES(4)) dut (
      .i_clock (clk),
      .i_reset (i_reset),
      .i_state (i_state),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_state (o_state),
      .o_valid (o_valid),
      .i_ready (i_ready)
   );

   function automatic logic [7:0] sboxModel(input logic [7:0] b);
      return sbox_tab[(255 - int'(b)) * 8 +: 8];
   endfunction

   function automatic logic [127:0] expectState(input logic [127:0] s);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[k*8 +: 8] = sboxModel(s[k*8 +: 8]);
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts and ends on a negedge; lat counts edges from the capture edge to the first o_valid sample.
   task automatic applyStimulus(input logic [127:0] st, input bit inject, output int lat);
      int w;
      i_state = st;
      i_valid = 1'b1;
      w = 0;
      while (!o_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!o_ready) checkOutput("handshake_wait", {127'd0, o_ready}, 128'd1);
      lat = 0;
      while (lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 1) i_valid = 1'b0;
         if (inject && lat == 2) begin
            i_valid = 1'b1;
            i_state = ~st;
         end
         if (inject && lat == 3) begin
            i_valid = 1'b0;
            i_state = st;
         end
         if (o_valid) break;
      end
   endtask

   initial begin
      int           lat;
      logic [127:0] st;
      logic         seen;
      i_reset = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_state = '0;

      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("reset_ready", {127'd0, o_ready}, 128'd0);
         checkOutput("reset_valid", {127'd0, o_valid}, 128'd0);
         checkOutput("reset_state", o_state, 128'd0);
      end
      i_reset = 1'b0;
      #1;
      checkOutput("idle_ready", {127'd0, o_ready}, 128'd1);

      applyStimulus(128'd0, 1'b0, lat);
      checkOutput("t1_latency", lat, 128'd5);
      checkOutput("t1_state", o_state, 128'h63636363636363636363636363636363);

      applyStimulus(128'h0f0e0d0c0b0a09080706050403020100, 1'b0, lat);
      checkOutput("t2_latency", lat, 128'd5);
      checkOutput("t2_state", o_state, 128'h76abd7fe2b670130c56f6bf27b777c63);
      @(posedge clk);
      @(negedge clk);
      checkOutput("t2_valid_pulse", {127'd0, o_valid}, 128'd0);
      checkOutput("t2_ready_next", {127'd0, o_ready}, 128'd1);

      st = 128'h00112233445566778899aabbccddeeff;
      applyStimulus(st, 1'b1, lat);
      checkOutput("t3_latency", lat, 128'd5);
      checkOutput("t3_state", o_state, expectState(st));
      @(posedge clk);
      @(negedge clk);
      checkOutput("t3_no_capture", {127'd0, o_valid}, 128'd0);

      st = 128'hdeadbeef0123456789abcdeffedcba98;
      i_state = st;
      i_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      i_reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("t4_state", o_state, 128'd0);
      checkOutput("t4_valid", {127'd0, o_valid}, 128'd0);
      checkOutput("t4_ready", {127'd0, o_ready}, 128'd0);
      i_reset = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         @(negedge clk);
         seen = seen | o_valid;
      end
      checkOutput("t4_no_valid", {127'd0, seen}, 128'd0);
      checkOutput("t4_ready_after", {127'd0, o_ready}, 128'd1);

      st = 128'h3243f6a8885a308d313198a2e0370734;
      i_ready = 1'b0;
      applyStimulus(st, 1'b0, lat);
      checkOutput("t5_latency", lat, 128'd5);
      checkOutput("t5_state", o_state, expectState(st));
`ifdef SUB_BYTES_SEQ_STALL_EN
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("t5_hold_valid", {127'd0, o_valid}, 128'd1);
         checkOutput("t5_hold_state", o_state, expectState(st));
         checkOutput("t5_hold_ready", {127'd0, o_ready}, 128'd0);
      end
      i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("t5_release_valid", {127'd0, o_valid}, 128'd0);
      checkOutput("t5_release_ready", {127'd0, o_ready}, 128'd1);
`else
      @(posedge clk);
      @(negedge clk);
      checkOutput("t5_pulse_valid", {127'd0, o_valid}, 128'd0);
      checkOutput("t5_pulse_ready", {127'd0, o_ready}, 128'd1);
      i_ready = 1'b1;
`endif

      for (int c = 0; c < 20000 && sweeps_done < 3; c++) @(negedge clk);
      checkOutput("sweeps_finished", sweeps_done, 128'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Independent instances exercise other lane counts with random back-to-back states.
   generate
      for (genvar g = 0; g < 3; g++) begin : g_sweep
         localparam int NL = (g == 0) ? 1 : ((g == 1) ? 2 : 16);

         logic         s_reset;
         logic         s_valid;
         logic         s_ready_in;
         logic         s_ready;
         logic         s_out_valid;
         logic [127:0] s_state;
         logic [127:0] s_out;

         sub_bytes_sequencer #(.N_LANES(NL)) u_dut (
            .i_clock (clk),
            .i_reset (s_reset),
            .i_state (s_state),
            .i_valid (s_valid),
            .o_ready (s_ready),
            .o_state (s_out),
            .o_valid (s_out_valid),
            .i_ready (s_ready_in)
         );

         initial begin
            logic [127:0] st;
            int           lat;
            int           w;
            s_reset    = 1'b1;
            s_valid    = 1'b0;
            s_ready_in = 1'b1;
            s_state    = '0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            s_reset = 1'b0;
            for (int n = 0; n < 50; n++) begin
               st      = {$urandom, $urandom, $urandom, $urandom};
               s_state = st;
               s_valid = 1'b1;
               w = 0;
               while (!s_ready && w < 50) begin
                  @(negedge clk);
                  w++;
               end
               lat = 0;
               while (lat < 100) begin
                  @(posedge clk);
                  lat++;
                  @(negedge clk);
                  s_valid = 1'b0;
                  if (s_out_valid) break;
               end
               checkOutput($sformatf("sweep%0d_latency", NL), lat, 128'(16 / NL + 1));
               checkOutput($sformatf("sweep%0d_state", NL), s_out, expectState(st));
            end
            sweeps_done++;
         end
      end
   endgenerate

endmodule
